// File: rtl/piano_pkg.sv
// Shared definitions for the piano slice: default note width and the
// arbiter mode encoding seen on the mode output.
package piano_pkg;

  localparam int unsigned DEFAULT_KEY_W = 4;
  localparam int unsigned MODE_W        = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_IDLE   = 2'd0,
    MODE_SWITCH = 2'd1,
    MODE_PLAY   = 2'd2,
    MODE_DUCK   = 2'd3
  } mode_e;

endpackage

// File: rtl/song_source_arbiter_if.sv
// Bundle between keyboard / song-player bank, the arbiter and the tone generator.
// The slave side is the arbiter; the master side drives sources and buttons.
interface song_source_arbiter_if
  import piano_pkg::*;
#(
  parameter int unsigned NUM_SONGS = 4,
  parameter int unsigned KEY_W     = DEFAULT_KEY_W
);
  localparam int unsigned IDX_W = $clog2(NUM_SONGS);

  logic                       live_key_on;
  logic [KEY_W-1:0]           live_key;
  logic [NUM_SONGS-1:0]       song_key_on;
  logic [NUM_SONGS*KEY_W-1:0] song_key;
  logic                       btn_play;
  logic                       btn_next;
  logic                       btn_stop;
  logic [NUM_SONGS-1:0]       player_rst;
  logic                       out_key_on;
  logic [KEY_W-1:0]           out_key;
  logic [IDX_W-1:0]           song_idx;
  logic [MODE_W-1:0]          mode;

  modport slave (
    input  live_key_on, live_key, song_key_on, song_key,
    input  btn_play, btn_next, btn_stop,
    output player_rst, out_key_on, out_key, song_idx, mode
  );

  modport master (
    output live_key_on, live_key, song_key_on, song_key,
    output btn_play, btn_next, btn_stop,
    input  player_rst, out_key_on, out_key, song_idx, mode
  );
endinterface

// File: rtl/song_source_arbiter_play_timer.sv
// Shared gap / hold-off counter: synchronous clear, count enable, and a
// terminal flag raised when the count equals the runtime last value.
module play_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic         o_tc
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_en)    r_count <= r_count + 1'b1;
  end

  assign o_tc = (r_count == i_last);
endmodule

// File: rtl/song_source_arbiter.sv
// Chooses live keyboard or the selected song player for the tone generator,
// with a silent gap on song start/switch and live-key ducking of the song.
module song_source_arbiter
  import piano_pkg::*;
#(
  parameter int unsigned NUM_SONGS      = 4,
  parameter int unsigned KEY_W          = DEFAULT_KEY_W,
  parameter int unsigned GAP_CYCLES     = 5_000_000,
  parameter int unsigned HOLDOFF_CYCLES = 25_000_000
) (
  input logic                  clk,
  input logic                  rst,
  song_source_arbiter_if.slave bus
);
  localparam int unsigned IDX_W   = $clog2(NUM_SONGS);
  localparam int unsigned MAX_LIM = (GAP_CYCLES > HOLDOFF_CYCLES) ? GAP_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned TW      = ($clog2(MAX_LIM) < 1) ? 1 : $clog2(MAX_LIM);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLDOFF_CYCLES - 1);

  mode_e                r_state;
  mode_e                w_next_state;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_next_idx;
  logic [IDX_W-1:0]     w_idx_inc;
  logic                 r_key_on;
  logic [KEY_W-1:0]     r_key;
  logic [NUM_SONGS-1:0] r_player_rst;
  logic                 w_song_on;
  logic [KEY_W-1:0]     w_song_key;
  logic                 w_clear;
  logic                 w_en;
  logic                 w_tc;
  logic [TW-1:0]        w_last;
  logic                 w_run;

  assign w_idx_inc = (r_idx == IDX_W'(NUM_SONGS - 1)) ? '0 : r_idx + 1'b1;

  always_comb begin
    w_song_on  = 1'b0;
    w_song_key = '0;
    for (int unsigned n = 0; n < NUM_SONGS; n++) begin
      if (r_idx == IDX_W'(n)) begin
        w_song_on  = bus.song_key_on[n];
        w_song_key = bus.song_key[n*KEY_W +: KEY_W];
      end
    end
  end

  // Priority: stop > next > play > live key > timer expiry.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    unique case (r_state)
      MODE_IDLE: begin
        if (!bus.btn_stop) begin
          if (bus.btn_next)      w_next_idx   = w_idx_inc;
          else if (bus.btn_play) w_next_state = MODE_SWITCH;
        end
      end
      MODE_SWITCH: begin
        if (w_tc) w_next_state = MODE_PLAY;
      end
      MODE_PLAY, MODE_DUCK: begin
        if (bus.btn_stop) begin
          w_next_state = MODE_IDLE;
        end else if (bus.btn_next) begin
          w_next_idx   = w_idx_inc;
          w_next_state = MODE_SWITCH;
        end else if (r_state == MODE_PLAY) begin
          if (bus.live_key_on) w_next_state = MODE_DUCK;
        end else if (!bus.live_key_on && w_tc) begin
          w_next_state = MODE_PLAY;
        end
      end
      default: w_next_state = MODE_IDLE;
    endcase
  end

  // One counter for both waits: cleared on any state change, and held at
  // zero in DUCK while the live key is down so the hold-off restarts.
  assign w_clear = (w_next_state != r_state) || (r_state == MODE_DUCK && bus.live_key_on);
  assign w_en    = (r_state == MODE_SWITCH) || (r_state == MODE_DUCK && !bus.live_key_on);
  assign w_last  = (r_state == MODE_SWITCH) ? GAP_LAST : HOLD_LAST;
  assign w_run   = (w_next_state == MODE_PLAY) || (w_next_state == MODE_DUCK);

  play_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_en    (w_en),
    .i_last  (w_last),
    .o_tc    (w_tc)
  );

  // player_rst follows the next state so the release lines up with the
  // first PLAY cycle; the key path follows the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= MODE_IDLE;
      r_idx        <= '0;
      r_key_on     <= 1'b0;
      r_key        <= '0;
      r_player_rst <= '1;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      unique case (r_state)
        MODE_SWITCH: r_key_on <= 1'b0;
        MODE_PLAY: begin
          r_key_on <= w_song_on;
          r_key    <= w_song_key;
        end
        default: begin
          r_key_on <= bus.live_key_on;
          r_key    <= bus.live_key;
        end
      endcase
      for (int unsigned n = 0; n < NUM_SONGS; n++) begin
        r_player_rst[n] <= !(w_run && (w_next_idx == IDX_W'(n)));
      end
    end
  end

  assign bus.mode       = r_state;
  assign bus.song_idx   = r_idx;
  assign bus.out_key_on = r_key_on;
  assign bus.out_key    = r_key;
  assign bus.player_rst = r_player_rst;
endmodule

// File: tb/tb_song_source_arbiter.sv
// Directed bench for song_source_arbiter with a small output scoreboard
// (NUM_SONGS=3, GAP_CYCLES=4, HOLDOFF_CYCLES=8).
module tb_song_source_arbiter;
  import piano_pkg::*;

  localparam int unsigned NS   = 3;
  localparam int unsigned KW   = 4;
  localparam int unsigned GAP  = 4;
  localparam int unsigned HOLD = 8;

  logic clk = 1'b0;
  logic rst;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  song_source_arbiter_if #(.NUM_SONGS(NS), .KEY_W(KW)) bus ();

  song_source_arbiter #(
    .NUM_SONGS      (NS),
    .KEY_W          (KW),
    .GAP_CYCLES     (GAP),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string         tag;
    logic          on;
    logic [KW-1:0] key;
  } exp_t;

  exp_t          sb_q[$];
  logic [KW-1:0] keys [NS];
  int unsigned   n;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_out(input string tag, input logic on, input logic [KW-1:0] key);
    exp_t e;
    e.tag = tag;
    e.on  = on;
    e.key = key;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb_q.pop_front();
    checks++;
    assert (bus.out_key_on === e.on && bus.out_key === e.key) else begin
      failures++;
      $error("FAIL %s observed on=%0b key=%0h expected on=%0b key=%0h",
             e.tag, bus.out_key_on, bus.out_key, e.on, e.key);
    end
  endtask

  task automatic out_cycle(input string tag, input logic on, input logic [KW-1:0] key);
    push_out(tag, on, key);
    step();
    pop_check();
  endtask

  // Called on the first SWITCH cycle; returns on the first PLAY cycle.
  task automatic gap_check(input string tag, input int unsigned exp_idx,
                           input logic [NS-1:0] exp_prst, input logic [KW-1:0] hold_key);
    int unsigned cnt = 0;
    int unsigned bad = 0;
    while (bus.mode == 2'd1 && cnt < 20) begin
      if (bus.out_key !== hold_key || bus.player_rst !== '1) bad++;
      if (cnt > 0 && bus.out_key_on !== 1'b0) bad++;
      cnt++;
      step();
    end
    chk({tag, "_gap_len"},   cnt, GAP);
    chk({tag, "_gap_quiet"}, bad, 0);
    chk({tag, "_mode"},      32'(bus.mode), 32'(2));
    chk({tag, "_idx"},       32'(bus.song_idx), exp_idx);
    chk({tag, "_prst"},      32'(bus.player_rst), 32'(exp_prst));
    chk({tag, "_out_on"},    32'(bus.out_key_on), 0);
    chk({tag, "_out_key"},   32'(bus.out_key), 32'(hold_key));
  endtask

  initial begin
    keys[0] = 4'd2;
    keys[1] = 4'd9;
    keys[2] = 4'd12;
    rst = 1'b1;
    bus.live_key_on = 1'b0;
    bus.live_key    = '0;
    bus.song_key_on = '0;
    bus.song_key    = '0;
    bus.btn_play    = 1'b0;
    bus.btn_next    = 1'b0;
    bus.btn_stop    = 1'b0;
    repeat (2) step();

    chk("rst_mode", 32'(bus.mode), 0);
    chk("rst_idx",  32'(bus.song_idx), 0);
    chk("rst_on",   32'(bus.out_key_on), 0);
    chk("rst_key",  32'(bus.out_key), 0);
    chk("rst_prst", 32'(bus.player_rst), 32'(3'b111));

    rst = 1'b0;
    bus.live_key_on = 1'b1;
    bus.live_key    = 4'd5;
    out_cycle("idle_live", 1'b1, 4'd5);
    chk("idle_mode", 32'(bus.mode), 0);
    chk("idle_prst", 32'(bus.player_rst), 32'(3'b111));

    bus.song_key_on = 3'b111;
    bus.song_key    = {keys[2], keys[1], keys[0]};
    bus.live_key_on = 1'b0;
    bus.btn_play    = 1'b1;
    out_cycle("play_edge", 1'b0, 4'd5);
    bus.btn_play = 1'b0;
    chk("switch_mode", 32'(bus.mode), 1);
    gap_check("start", 0, 3'b110, 4'd5);
    out_cycle("song0", 1'b1, keys[0]);
    bus.song_key_on = 3'b110;
    out_cycle("song0_off", 1'b0, keys[0]);
    bus.song_key_on = 3'b111;
    out_cycle("song0_on", 1'b1, keys[0]);

    // Live press for three cycles, then release.
    bus.live_key_on = 1'b1;
    bus.live_key    = 4'd7;
    out_cycle("duck_edge", 1'b1, keys[0]);
    chk("duck_mode", 32'(bus.mode), 3);
    chk("duck_prst", 32'(bus.player_rst), 32'(3'b110));
    out_cycle("duck_live1", 1'b1, 4'd7);
    out_cycle("duck_live2", 1'b1, 4'd7);
    bus.live_key_on = 1'b0;
    n = 0;
    while (bus.mode == 2'd3 && n < 40) begin n++; step(); end
    chk("holdoff_len", n, HOLD);
    chk("holdoff_mode", 32'(bus.mode), 2);
    chk("holdoff_out_on", 32'(bus.out_key_on), 0);

    // Re-press five cycles after release restarts the hold-off.
    bus.live_key_on = 1'b1;
    step();
    bus.live_key_on = 1'b0;
    repeat (5) step();
    chk("repress_mode", 32'(bus.mode), 3);
    bus.live_key_on = 1'b1;
    step();
    bus.live_key_on = 1'b0;
    n = 0;
    while (bus.mode == 2'd3 && n < 40) begin n++; step(); end
    chk("holdoff_restart", n, HOLD);

    for (int unsigned i = 0; i < 3; i++) begin
      int unsigned nxt;
      nxt = (i + 1) % NS;
      bus.btn_next = 1'b1;
      out_cycle("next_edge", 1'b1, keys[i]);
      bus.btn_next = 1'b0;
      gap_check("next", nxt, ~(NS'(1) << nxt), keys[i]);
      out_cycle("next_song", 1'b1, keys[nxt]);
    end

    // stop and next together while ducked.
    bus.live_key_on = 1'b1;
    out_cycle("duck2_edge", 1'b1, keys[0]);
    chk("duck2_mode", 32'(bus.mode), 3);
    bus.btn_stop = 1'b1;
    bus.btn_next = 1'b1;
    out_cycle("stopnext_edge", 1'b1, 4'd7);
    bus.btn_stop    = 1'b0;
    bus.btn_next    = 1'b0;
    bus.live_key_on = 1'b0;
    chk("stopnext_mode", 32'(bus.mode), 0);
    chk("stopnext_idx",  32'(bus.song_idx), 0);
    chk("stopnext_prst", 32'(bus.player_rst), 32'(3'b111));

    for (int unsigned i = 0; i < 3; i++) begin
      bus.btn_next = 1'b1;
      step();
      bus.btn_next = 1'b0;
      chk("idle_next_idx",  32'(bus.song_idx), (i + 1) % NS);
      chk("idle_next_mode", 32'(bus.mode), 0);
    end

    // Async reset in the middle of a gap.
    bus.btn_next = 1'b1;
    step();
    bus.btn_next    = 1'b0;
    bus.live_key_on = 1'b1;
    bus.live_key    = 4'd5;
    bus.btn_play    = 1'b1;
    out_cycle("play2_edge", 1'b1, 4'd5);
    bus.btn_play    = 1'b0;
    bus.live_key_on = 1'b0;
    step();
    step();
    chk("presrst_mode", 32'(bus.mode), 1);
    chk("presrst_idx",  32'(bus.song_idx), 1);
    rst = 1'b1;
    #2;
    chk("arst_mode", 32'(bus.mode), 0);
    chk("arst_idx",  32'(bus.song_idx), 0);
    chk("arst_on",   32'(bus.out_key_on), 0);
    chk("arst_key",  32'(bus.out_key), 0);
    chk("arst_prst", 32'(bus.player_rst), 32'(3'b111));
    step();
    rst = 1'b0;
    bus.btn_play = 1'b1;
    step();
    bus.btn_play = 1'b0;
    gap_check("after_rst", 0, 3'b110, 4'd5);
    out_cycle("after_rst_song", 1'b1, keys[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/song_source_arbiter.md
# song_source_arbiter

Arbitrates the single tone-generator input (`key_on`/`key`) between the live keyboard and NUM_SONGS auto-play song players. The block selects the active song, holds all other players in reset, and inserts a silent gap on every song start or switch. It lets a live key press temporarily override (duck) the playing song. It sits between the keyboard scanner / song-player bank and the tone generator.

## Interface
Parameters:
- NUM_SONGS, 4, number of song players (≥2)
- KEY_W, 4, note code width
- GAP_CYCLES, 5_000_000, silent cycles on song start/switch (≥1)
- HOLDOFF_CYCLES, 25_000_000, cycles after live release before the song output resumes (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- live_key_on  in  1  keyboard note active
- live_key  in  KEY_W  keyboard note code
- song_key_on  in  NUM_SONGS  per-player key_on
- song_key  in  NUM_SONGS*KEY_W  per-player key; player n occupies bits [n*KEY_W +: KEY_W]
- btn_play  in  1  single-cycle pulse (pre-debounced)
- btn_next  in  1  single-cycle pulse
- btn_stop  in  1  single-cycle pulse
- player_rst  out  NUM_SONGS  reset to each song player, active-high
- out_key_on  out  1  to tone generator
- out_key  out  KEY_W  to tone generator
- song_idx  out  clog2(NUM_SONGS)  selected song
- mode  out  2  IDLE=0, SWITCH=1, PLAY=2, DUCK=3

## Operation
- FSM states and transitions:
  - IDLE: output = live. All player_rst=1. btn_next → song_idx=(song_idx+1) mod NUM_SONGS, stay IDLE. btn_play → SWITCH.
  - SWITCH: out_key_on=0, out_key holds its last value, all player_rst=1. Exactly GAP_CYCLES cycles, then → PLAY.
  - PLAY: output = song[song_idx]. player_rst = all ones except bit song_idx=0. live_key_on=1 → DUCK. btn_next → advance song_idx, → SWITCH. btn_stop → IDLE. btn_play ignored.
  - DUCK: output = live. The selected player keeps running, so song position advances while muted. Hold-off counter clears while live_key_on=1 and counts while live_key_on=0. Reaching HOLDOFF_CYCLES → PLAY. btn_next and btn_stop behave as in PLAY.
- Same-cycle priority: btn_stop > btn_next > btn_play > live_key_on > timer expiry.
- song_idx wraps from NUM_SONGS-1 to 0.
- A switch while in DUCK discards the hold-off count.
- A single counter serves both the gap and the hold-off. It is cleared on every state entry.

## Timing
- All outputs are registered. Output selection takes effect on the cycle after the state changes. Data path from the selected source to out_key_on/out_key has 1-cycle latency.
- Reset values: mode=IDLE, song_idx=0, out_key_on=0, out_key=0, player_rst=all ones, counter=0.
- Reset mid-song returns to IDLE immediately (asynchronous). All players are held in reset.
- player_rst[song_idx] falls on the first PLAY cycle. The player's first note appears no earlier than 2 cycles after that.
- SWITCH entered at cycle t: the PLAY state is visible at cycle t+GAP_CYCLES.
- DUCK: if live_key_on falls at cycle r and stays low, PLAY is visible at cycle r+HOLDOFF_CYCLES.

## Structure
- Shared package `piano_pkg`: KEY_W, mode/state encoding constants. Song players and the keyboard scanner import the same package.
- One sub-module `play_timer`: counter with clear, enable, and a terminal-count flag against a runtime limit (GAP_CYCLES or HOLDOFF_CYCLES). Width is clog2 of the larger limit.

## Test plan
Bench parameters: NUM_SONGS=3, GAP_CYCLES=4, HOLDOFF_CYCLES=8.
- Reset, live_key_on=1, live_key=5 → out_key_on=1, out_key=5 one cycle later, mode=0, player_rst=3'b111.
- btn_play at t → mode=1 with out_key_on=0 for 4 cycles; mode=2 at t+4; player_rst=3'b110; song0 key_on=1/key=2 passes through with 1-cycle latency.
- In PLAY: live key 7 pressed 3 cycles then released → mode=3, out_key=7; mode=2 exactly 8 cycles after release. A re-press at release+5 restarts the count.
- btn_next three times in PLAY (each after a completed SWITCH) → song_idx 1, 2, 0. player_rst goes 3'b101, 3'b011, 3'b110. Each switch shows 4 silent cycles.
- Same cycle btn_stop+btn_next in DUCK → mode=0, song_idx unchanged, player_rst=3'b111.
- Assert rst during SWITCH at count 2 → all outputs at reset values immediately; a subsequent btn_play gives a full 4-cycle gap.
